starter_data_fifo: RTL and testbench

- Parametrised successor to the 8-bit data/valid stream used between starter testbench components and the DUT.
- Accepts a valid-only input stream, which has no backpressure. Buffers it in a DEPTH-entry FIFO.
- Presents a valid/ready output stream.
- Counts and flags words dropped on overflow, so monitors and scoreboards can detect loss instead of silently missing data.

---
 rtl/starter_pkg.sv | 14 +
 rtl/starter_sat_counter.sv | 24 ++
 rtl/starter_data_fifo.sv | 99 +++++++++
 tb/tb_starter_data_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/starter_pkg.sv
// Shared defaults and helpers for the starter stream components.
package starter_pkg;

  localparam int STARTER_DATA_W     = 8;
  localparam int STARTER_FIFO_DEPTH = 16;

  typedef logic [STARTER_DATA_W-1:0] starter_data_t;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/starter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment restarts the count at 1 so the coincident event is not lost.
module starter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count events, holding at all-ones once saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/starter_data_fifo.sv
// First-word-fall-through FIFO bridging a valid-only producer (no
// backpressure) to a valid/ready consumer. Words arriving while full and
// not being drained are dropped and accounted for in overflow/drop_cnt.
module starter_data_fifo
  import starter_pkg::*;
#(
  parameter int DATA_W    = STARTER_DATA_W,
  parameter int DEPTH     = STARTER_FIFO_DEPTH,
  parameter int AFULL_LVL = 12,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      almost_full,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_cnt,
  input  logic                      clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              push;
  logic              drop;
  logic [LVL_W-1:0]  level_nxt;

  // Handshake decode and next occupancy; a pop frees a slot for a push
  // in the same cycle, so a full FIFO being drained never drops.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = in_valid & ((level < LVL_W'(DEPTH)) | pop);
    drop      = in_valid & ~push;
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and flags registered from the next-state level so
  // out_valid/almost_full always agree with level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level       <= level_nxt;
      out_valid   <= (level_nxt != '0);
      almost_full <= (level_nxt >= LVL_W'(AFULL_LVL));
    end
  end

  // Sticky loss flag; a drop coinciding with a clear still leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_stats) begin
      overflow <= 1'b0;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  starter_sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (drop),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_starter_data_fifo.sv
// Directed bench for starter_data_fifo: a default instance plus a CNT_W=2
// instance driven by the same stimulus to exercise counter saturation.
module tb_starter_data_fifo;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        clr_stats;

  logic [7:0]  out_data,  out_data2;
  logic        out_valid, out_valid2;
  logic [4:0]  level,     level2;
  logic        almost_full, almost_full2;
  logic        overflow,  overflow2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];

  starter_data_fifo dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_stats(clr_stats)
  );

  starter_data_fifo #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .level(level2), .almost_full(almost_full2), .overflow(overflow2),
    .drop_cnt(drop_cnt2), .clr_stats(clr_stats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and keep a queue image of the FIFO for the random test.
  task automatic cycle();
    bit p, w;
    p = (q.size() != 0) && out_ready;
    w = in_valid && ((q.size() < 16) || p);
    @(posedge clk);
    #1;
    if (rst) q.delete();
    else begin
      if (p) void'(q.pop_front());
      if (w) q.push_back(in_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0; clr_stats = 1'b0;
    cycle();
    cycle();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_order();
    logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = d[i];
      n_cmp++; if (out_valid !== (i != 0)) begin n_bad++; $display("FAIL order_pre_valid[%0d]: got %b want %b", i, out_valid, i != 0); end
      cycle();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== d[i]) begin n_bad++; $display("FAIL order_data[%0d]: got %h want %h", i, out_data, d[i]); end
      n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL order_level[%0d]: got %0d want 1", i, level); end
    end
    in_valid = 1'b0;
    cycle();
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL order_empty: got level %0d valid %b want 0 0", level, out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL order_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_fill_drop();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      cycle();
      n_cmp++; if (level !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 12)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, i + 1 >= 12); end
    end
    in_data = 8'hAA;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL drop_level: got %0d want 16", level); end
    n_cmp++; if (overflow !== 1'b1 || overflow2 !== 1'b1) begin n_bad++; $display("FAIL drop_overflow: got %b/%b want 1/1", overflow, overflow2); end
    n_cmp++; if (drop_cnt !== 16'd1 || drop_cnt2 !== 2'd1) begin n_bad++; $display("FAIL drop_cnt: got %0d/%0d want 1/1", drop_cnt, drop_cnt2); end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin n_bad++; $display("FAIL drain_data[%0d]: got %b/%h want 1/%h", k, out_valid, out_data, 8'(k)); end
      cycle();
    end
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL drain_empty: got %0d/%b/%h want 0/0/00", level, out_valid, out_data); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      cycle();
    end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fullpop_fill: got %0d want 16", level); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_data = 8'h80 + 8'(j);
      n_cmp++; if (out_data !== 8'h40 + 8'(j)) begin n_bad++; $display("FAIL fullpop_data[%0d]: got %h want %h", j, out_data, 8'h40 + 8'(j)); end
      cycle();
      n_cmp++; if (level !== 5'd16 || drop_cnt !== 16'd1) begin n_bad++; $display("FAIL fullpop_level[%0d]: got %0d/%0d want 16/1", j, level, drop_cnt); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_sat_clear();
    logic [1:0] exp2;
    out_ready = 1'b0; in_valid = 1'b0; clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || drop_cnt2 !== 2'd0) begin n_bad++; $display("FAIL clr_initial: got %b/%0d/%0d want 0/0/0", overflow, drop_cnt, drop_cnt2); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      cycle();
      exp2 = (i + 1 >= 3) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (drop_cnt2 !== exp2) begin n_bad++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", i, drop_cnt2, exp2); end
      n_cmp++; if (drop_cnt !== 16'(i + 1)) begin n_bad++; $display("FAIL sat_cnt16[%0d]: got %0d want %0d", i, drop_cnt, i + 1); end
    end
    clr_stats = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    cycle();
    n_cmp++; if (drop_cnt !== 16'd1 || drop_cnt2 !== 2'd1 || overflow !== 1'b1 || overflow2 !== 1'b1) begin n_bad++; $display("FAIL clr_with_drop: got %0d/%0d/%b/%b want 1/1/1/1", drop_cnt, drop_cnt2, overflow, overflow2); end
    in_valid = 1'b0;
    cycle();
    clr_stats = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd0 || drop_cnt2 !== 2'd0 || overflow !== 1'b0 || overflow2 !== 1'b0) begin n_bad++; $display("FAIL clr_alone: got %0d/%0d/%b/%b want 0/0/0/0", drop_cnt, drop_cnt2, overflow, overflow2); end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL clr_level: got %0d want 16", level); end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] e;
      e = (k < 11) ? 8'h45 + 8'(k) : 8'h80 + 8'(k - 11);
      n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL sat_drain[%0d]: got %h want %h", k, out_data, e); end
      cycle();
    end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL sat_drain_level: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      cycle();
    end
    n_cmp++; if (level !== 5'd10) begin n_bad++; $display("FAIL rmid_fill: got %0d want 10", level); end
    rst = 1'b1; in_data = 8'h99;
    cycle();
    rst = 1'b0;
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL rmid_after: got %0d/%b/%h want 0/0/00", level, out_valid, out_data); end
    in_data = 8'h5A;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== 5'd1) begin n_bad++; $display("FAIL rmid_push: got %b/%h/%0d want 1/5a/1", out_valid, out_data, level); end
    out_ready = 1'b1;
    cycle();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rmid_pop: got %0d want 0", level); end
  endtask

  task automatic test_random_wrap();
    int sent = 0;
    int cyc = 0;
    while (cyc < 3000 && (sent < 100 || q.size() != 0)) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 100) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      if (in_valid) sent++;
      n_cmp++; if (out_valid !== (q.size() != 0) || level !== 5'(q.size()) || almost_full !== (q.size() >= 12)) begin n_bad++; $display("FAIL rand_state[%0d]: got %b/%0d/%b want %b/%0d/%b", cyc, out_valid, level, almost_full, q.size() != 0, q.size(), q.size() >= 12); end
      if (q.size() != 0) begin
        n_cmp++; if (out_data !== q[0]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", cyc, out_data, q[0]); end
      end
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (sent != 100 || q.size() != 0) begin n_bad++; $display("FAIL rand_timeout: got sent %0d left %0d want 100 0", sent, q.size()); end
    n_cmp++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL rand_drops: got %0d/%b want 0/0", drop_cnt, overflow); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill_drop();
    test_full_pop();
    test_sat_clear();
    test_reset_mid();
    test_random_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
